// File: rtl/div_if.sv
// Start/busy/done handshake bundle for the multi-cycle divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: one shift/subtract step per cycle, registered results.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise the divide is unsigned.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);
  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             div_zero_q, div_zero_d;
  logic             busy_o, done_o;

  logic [WIDTH-1:0] r_shift, q_step, r_step;
  logic [WIDTH-1:0] abs_dvd, abs_dvs, fix_quo, fix_rem;
  logic [WIDTH:0]   trial;
  logic             dvs_zero;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign dvs_zero = (dvs_q == '0);

  // One restoring step; the shared A + ~B + 1 subtract, one bit wider so its MSB is the borrow.
  always_comb begin
    r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    trial   = {1'b0, r_shift} + {1'b1, ~d_q} + {{WIDTH{1'b0}}, 1'b1};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
      q_step = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_step = r_shift;
      q_step = {q_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef DIV_SIGNED_EN
  always_comb begin
    abs_dvd = dvd_q[WIDTH-1] ? (~dvd_q + ONE) : dvd_q;
    abs_dvs = dvs_q[WIDTH-1] ? (~dvs_q + ONE) : dvs_q;
    fix_quo = (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]) ? (~q_step + ONE) : q_step;
    fix_rem = dvd_q[WIDTH-1] ? (~r_step + ONE) : r_step;
  end
`else
  always_comb begin
    abs_dvd = dvd_q;
    abs_dvs = dvs_q;
    fix_quo = q_step;
    fix_rem = r_step;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ITER covers WIDTH-1 steps; FIX performs the final step together with the sign fix-up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_PREP;
      S_PREP: state_d = dvs_zero ? S_DONE : S_ITER;
      S_ITER: if (cnt_inc == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    q_d        = q_q;
    r_d        = r_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d      = bus.dividend;
          dvs_d      = bus.divisor;
          div_zero_d = 1'b0;
        end
      end
      S_PREP: begin
        if (dvs_zero) begin
          quo_d      = '1;
          rem_d      = dvd_q;
          div_zero_d = 1'b1;
        end else begin
          q_d   = abs_dvd;
          r_d   = '0;
          d_d   = abs_dvs;
          cnt_d = '0;
        end
      end
      S_ITER: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_inc;
      end
      S_FIX: begin
        quo_d = fix_quo;
        rem_d = fix_rem;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;
endmodule
